// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-requester arbiter and sequencer for the shared memory port
package mem_port_pkg;
  typedef enum logic [1:0] {MEM_ACCESS_BYTE, MEM_ACCESS_HALF, MEM_ACCESS_WORD} mem_access_t;
  typedef logic [3:0] mem_exception_mask_t;
endpackage

module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic [31:0]         p0_addr,
  input  logic [31:0]         p0_wr_data,
  input  logic                p0_wr_ena,
  input  mem_access_t         p0_access,
  output logic                p0_gnt,
  output logic                p0_done,
  output logic [31:0]         p0_rd_data,
  output mem_exception_mask_t p0_err,
  input  logic                p1_req,
  input  logic [31:0]         p1_addr,
  input  logic [31:0]         p1_wr_data,
  input  logic                p1_wr_ena,
  input  mem_access_t         p1_access,
  output logic                p1_gnt,
  output logic                p1_done,
  output logic [31:0]         p1_rd_data,
  output mem_exception_mask_t p1_err,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [31:0]         mem_rd_data,
  input  mem_exception_mask_t mem_exception
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                owner_q, last_q, we_q, take, win;
  logic [31:0]         addr_q, wd_q;
  mem_access_t         acc_q;
  logic [31:0]         rd0_q, rd1_q;
  mem_exception_mask_t err0_q, err1_q;
  always_comb begin
    win     = (p0_req && p1_req) ? ~last_q : p1_req;
    take    = rst && state_q == S_IDLE && (p0_req || p1_req);
    state_d = state_q == S_IDLE   ? (take ? S_ACCESS : S_IDLE) :
              state_q == S_ACCESS ? (cnt_q == 4'd0 ? S_RESP : S_ACCESS) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
      acc_q   <= MEM_ACCESS_BYTE;
      rd0_q   <= 32'd0;
      rd1_q   <= 32'd0;
      err0_q  <= '0;
      err1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= win;
        last_q  <= win;
        cnt_q   <= CNT_INIT;
        addr_q  <= win ? p1_addr    : p0_addr;
        wd_q    <= win ? p1_wr_data : p0_wr_data;
        we_q    <= win ? p1_wr_ena  : p0_wr_ena;
        acc_q   <= win ? p1_access  : p0_access;
      end
      if (state_q == S_ACCESS) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          if (owner_q) begin
            rd1_q  <= mem_rd_data;
            err1_q <= mem_exception;
          end else begin
            rd0_q  <= mem_rd_data;
            err0_q <= mem_exception;
          end
        end
      end
    end
  end
  // write strobe only in the first access cycle, i.e. while cnt still holds its initial value
  assign mem_wr_ena  = rst && state_q == S_ACCESS && cnt_q == CNT_INIT && we_q;
  assign mem_access  = state_q == S_ACCESS ? acc_q : MEM_ACCESS_WORD;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wd_q;
  assign p0_gnt      = take && !win;
  assign p1_gnt      = take && win;
  assign p0_done     = rst && state_q == S_RESP && !owner_q;
  assign p1_done     = rst && state_q == S_RESP && owner_q;
  assign p0_rd_data  = rd0_q;
  assign p1_rd_data  = rd1_q;
  assign p0_err      = err0_q;
  assign p1_err      = err1_q;
endmodule
